// File: rtl/prime_check_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one prime_num_check between two requesters,
// with handshake sequencing, a hung-checker timeout and a prime counter.
module prime_check_sched #(
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [9:0]  num0,
  input  logic [9:0]  num1,
  output logic        ack0,
  output logic        ack1,
  output logic        prime,
  output logic        err,
  output logic        busy,
  output logic [15:0] prime_cnt,
  output logic        chk_start,
  output logic [9:0]  chk_num,
  input  logic        chk_done,
  input  logic        chk_prime
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_START,
    S_RUN,
    S_RESP
  } state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state_q;
  logic        id_q;
  logic        rr_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        prime_q;
  logic        err_q;
  logic        chk_start_q;
  logic [9:0]  chk_num_q;
  logic [15:0] prime_cnt_q;
  logic [15:0] timer_q;

  logic        grant_vld;
  logic        grant_id;
  logic [15:0] timer_d;
  logic        timed_out;
  logic        fin_ok;

  // When both request, serve the one that was not served last.
  always_comb begin
    grant_vld = req0 | req1;
    grant_id  = (req0 & req1) ? ~rr_q : req1;
    timer_d   = timer_q + 16'd1;
    timed_out = ((state_q == S_START) || (state_q == S_RUN)) && (timer_q == TIMEOUT_W);
    fin_ok    = (state_q == S_RUN) && chk_done && !timed_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      id_q        <= 1'b0;
      rr_q        <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      prime_q     <= 1'b0;
      err_q       <= 1'b0;
      chk_start_q <= 1'b0;
      chk_num_q   <= 10'd0;
      prime_cnt_q <= 16'd0;
      timer_q     <= 16'd0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_SYNC: begin
          if (chk_done) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (grant_vld) begin
            id_q        <= grant_id;
            chk_num_q   <= grant_id ? num1 : num0;
            timer_q     <= 16'd0;
            chk_start_q <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          if (!timed_out) begin
            timer_q <= timer_d;
            if (!chk_done) begin
              chk_start_q <= 1'b0;
              state_q     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!timed_out) timer_q <= timer_d;
        end
        S_RESP: begin
          rr_q    <= id_q;
          prime_q <= 1'b0;
          err_q   <= 1'b0;
          if (prime_q) prime_cnt_q <= prime_cnt_q + 16'd1;
          state_q <= err_q ? S_SYNC : S_IDLE;
        end
        default: state_q <= S_SYNC;
      endcase

      // Completion or abort: result and ack are registered together for one cycle.
      if (fin_ok || timed_out) begin
        ack0_q      <= ~id_q;
        ack1_q      <= id_q;
        prime_q     <= fin_ok & chk_prime;
        err_q       <= timed_out;
        chk_start_q <= 1'b0;
        state_q     <= S_RESP;
      end
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign prime     = prime_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign prime_cnt = prime_cnt_q;
  assign chk_start = chk_start_q;
  assign chk_num   = chk_num_q;

endmodule

// File: tb/tb_prime_check_sched.sv
`timescale 1ns/1ps
// Bench for prime_check_sched: behavioural checker model, table vectors,
// random traffic against a trial-division reference and corner sequences.
module tb_prime_check_sched;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [9:0]  num0 = 10'd0;
  logic [9:0]  num1 = 10'd0;
  logic        ack0, ack1, prime, err, busy, chk_start;
  logic [15:0] prime_cnt;
  logic [9:0]  chk_num;
  logic        chk_done = 1'b0;
  logic        chk_prime = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int last_served = 1;

  bit         m_test = 1'b1;
  bit         m_stuck = 1'b0;
  int         m_cnt = 6;
  int         m_div = 0;
  logic [9:0] m_num = 10'd0;
  logic       prev_done = 1'b0;

  typedef struct {
    logic [9:0] num;
    logic       exp_prime;
  } vec_t;
  vec_t tbl [7];

  prime_check_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .num0(num0), .num1(num1),
    .ack0(ack0), .ack1(ack1), .prime(prime), .err(err), .busy(busy),
    .prime_cnt(prime_cnt), .chk_start(chk_start), .chk_num(chk_num),
    .chk_done(chk_done), .chk_prime(chk_prime)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Checker model: DONE high when idle, start sampled on divider ticks, no reset.
  always @(posedge clk) begin
    m_div <= (m_div == 15) ? 0 : m_div + 1;
    if (m_stuck) begin
      chk_done  <= 1'b1;
      chk_prime <= 1'b1;
    end else if (m_test || m_div == 15) begin
      if (chk_done) begin
        if (chk_start) begin
          chk_done <= 1'b0;
          m_cnt    <= 1 + int'(chk_num[1:0]);
          m_num    <= chk_num;
        end
      end else if (m_cnt <= 1) begin
        chk_done  <= 1'b1;
        chk_prime <= is_prime(int'(m_num));
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Whenever the checker finishes, the start strobe must already be low.
  always @(negedge clk) begin
    if (rst_n && !prev_done && chk_done) chk("start_low_at_done", 32'(chk_start), 32'd0);
    prev_done = chk_done;
  end

  task automatic raise(input int id, input logic [9:0] n);
    if (id == 0) begin num0 = n; req0 = 1'b1; end
    else begin num1 = n; req1 = 1'b1; end
  endtask

  task automatic drop(input int id);
    if (id == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic wait_ack(input int id, input logic [9:0] n, input logic ep, input logic ee,
                          input string nm, output int t_start, output int t_ack);
    bit got = 1'b0;
    bit seen = 1'b0;
    t_start = -1;
    t_ack = -1;
    for (int i = 0; i < 800 && !got; i++) begin
      @(negedge clk);
      if (chk_start && !seen) begin
        seen = 1'b1;
        t_start = cyc;
        chk({nm, "_chk_num"}, 32'(chk_num), 32'(n));
      end
      if (ack0 || ack1) begin
        got = 1'b1;
        t_ack = cyc;
        chk({nm, "_ack_id"}, 32'({ack1, ack0}), (id == 0) ? 32'd1 : 32'd2);
        chk({nm, "_prime"}, 32'(prime), 32'(ep & ~ee));
        chk({nm, "_err"}, 32'(err), 32'(ee));
        drop(id);
        last_served = id;
        if (ep && !ee) exp_cnt++;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_ack: got no ack expected ack%0d within 800 cycles", nm, id);
      drop(id);
      return;
    end
    @(negedge clk);
    chk({nm, "_ack_pulse"}, 32'({ack1, ack0}), 32'd0);
    chk({nm, "_prime_cnt"}, 32'(prime_cnt), 32'(exp_cnt));
    chk({nm, "_busy_after"}, 32'(busy), 32'(ee));
  endtask

  task automatic serve(input int id, input logic [9:0] n, input logic ep, input string nm);
    int ts, ta;
    raise(id, n);
    wait_ack(id, n, ep, 1'b0, nm, ts, ta);
  endtask

  task automatic pair(input logic [9:0] n0, input logic [9:0] n1, input string nm);
    int ts, ta;
    int first;
    first = (last_served == 0) ? 1 : 0;
    raise(0, n0);
    raise(1, n1);
    if (first == 0) begin
      wait_ack(0, n0, is_prime(int'(n0)), 1'b0, {nm, "_a"}, ts, ta);
      wait_ack(1, n1, is_prime(int'(n1)), 1'b0, {nm, "_b"}, ts, ta);
    end else begin
      wait_ack(1, n1, is_prime(int'(n1)), 1'b0, {nm, "_a"}, ts, ta);
      wait_ack(0, n0, is_prime(int'(n0)), 1'b0, {nm, "_b"}, ts, ta);
    end
  endtask

  initial begin
    int ts, ta;
    bit extra;
    bit seen;
    logic [9:0] r0, r1;

    tbl[0] = '{10'd0,    1'b0};
    tbl[1] = '{10'd1,    1'b0};
    tbl[2] = '{10'd2,    1'b1};
    tbl[3] = '{10'd3,    1'b1};
    tbl[4] = '{10'd4,    1'b0};
    tbl[5] = '{10'd1021, 1'b1};
    tbl[6] = '{10'd1023, 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_chk_start", 32'(chk_start), 32'd0);
    chk("rst_acks", 32'({ack1, ack0}), 32'd0);
    chk("rst_prime_err", 32'({prime, err}), 32'd0);
    chk("rst_chk_num", 32'(chk_num), 32'd0);
    chk("rst_prime_cnt", 32'(prime_cnt), 32'd0);
    rst_n = 1'b1;

    serve(0, 10'd7, 1'b1, "single7");

    // Simultaneous requests: reset favours req0, then alternates on last served
    pair(10'd9, 10'd13, "pair1");
    pair(10'd9, 10'd13, "pair2");
    serve(0, 10'd2, 1'b1, "pre_pair3");
    pair(10'd15, 10'd31, "pair3");

    for (int m = 0; m < 2; m++) begin
      m_test = (m == 0);
      for (int i = 0; i < 7; i++)
        serve(i % 2, tbl[i].num, tbl[i].exp_prime, $sformatf("tbl%0d_t%0d", i, m_test));
    end

    for (int k = 0; k < 14; k++) begin
      int kind;
      m_test = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 2);
      r0 = 10'($urandom);
      r1 = 10'($urandom);
      if (kind == 2) pair(r0, r1, $sformatf("rnd%0d_pair", k));
      else if (kind == 1) serve(1, r1, is_prime(int'(r1)), $sformatf("rnd%0d_r1", k));
      else serve(0, r0, is_prime(int'(r0)), $sformatf("rnd%0d_r0", k));
    end

    // Request withdrawn right after grant
    m_test = 1'b1;
    raise(0, 10'd13);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = chk_start;
    end
    chk("drop_granted", 32'(seen), 32'd1);
    drop(0);
    wait_ack(0, 10'd13, 1'b1, 1'b0, "drop", ts, ta);
    extra = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (chk_start || ack0 || ack1) extra = 1'b1;
    end
    chk("drop_no_second_txn", 32'(extra), 32'd0);

    // Hung checker: DONE stuck high, abort after TIMEOUT
    m_stuck = 1'b1;
    @(negedge clk);
    raise(0, 10'd4);
    wait_ack(0, 10'd4, 1'b0, 1'b1, "timeout", ts, ta);
    chk("timeout_latency", 32'(ta - ts), 32'(TO + 1));
    m_stuck = 1'b0;
    serve(1, 10'd17, 1'b1, "after_timeout");

    // Reset asserted mid-RUN
    m_test = 1'b0;
    raise(0, 10'd1019);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = !chk_done;
    end
    chk("mid_run_entered", 32'(seen), 32'd1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'({busy, chk_start, ack0, ack1, prime, err}), 32'b100000);
    chk("async_rst_num_cnt", {6'd0, chk_num, prime_cnt}, 32'd0);
    exp_cnt = 0;
    last_served = 1;
    drop(0);
    extra = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1) extra = 1'b1;
    end
    chk("rst_no_ack", 32'(extra), 32'd0);
    rst_n = 1'b1;
    raise(1, 10'd11);
    for (int i = 0; i < 200 && !chk_done; i++) begin
      @(negedge clk);
      if (!chk_done) chk("sync_hold", 32'({busy, chk_start, ack0, ack1}), 32'b1000);
    end
    wait_ack(1, 10'd11, 1'b1, 1'b0, "post_rst", ts, ta);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
